// File: rtl/smi_stream_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : smi_stream_ctrl_if
// Brief    : Host-side SMI strobe bus plus IOC register bus of the stream controller.
// Revision : 1.0
// ============================================================================
interface smi_stream_ctrl_if #(
    parameter int SMI_W = 8
);
    logic [4:0]       i_ioc;
    logic [7:0]       i_data_in;
    logic [7:0]       o_data_out;
    logic             i_cs;
    logic             i_fetch_cmd;
    logic             i_load_cmd;
    logic             i_smi_soe_se;
    logic             i_smi_swe_srw;
    logic [SMI_W-1:0] i_smi_data_in;
    logic [SMI_W-1:0] o_smi_data_out;
    logic             o_smi_read_req;
    logic             o_smi_write_req;

    modport master (
        output i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
        output i_smi_soe_se, i_smi_swe_srw, i_smi_data_in,
        input  o_data_out, o_smi_data_out, o_smi_read_req, o_smi_write_req
    );

    modport slave (
        input  i_ioc, i_data_in, i_cs, i_fetch_cmd, i_load_cmd,
        input  i_smi_soe_se, i_smi_swe_srw, i_smi_data_in,
        output o_data_out, o_smi_data_out, o_smi_read_req, o_smi_write_req
    );
endinterface
`default_nettype wire

// File: rtl/smi_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : smi_stream_ctrl
// Brief    : Synchronous SMI byte-stream bridge to NUM_CH RX/TX FIFO pairs.
// Revision : 1.0
// ============================================================================
module smi_stream_ctrl #(
    parameter int         SMI_W   = 8,
    parameter int         WORD_W  = 32,
    parameter int         NUM_CH  = 2,
    parameter int         CNT_W   = 8,
    parameter logic [7:0] VERSION = 8'h02,
    localparam int        CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  wire logic                     i_sys_clk,
    input  wire logic                     i_rst,
    smi_stream_ctrl_if.slave              bus,
    output logic [NUM_CH-1:0]             o_rx_fifo_pull,
    input  wire logic [NUM_CH*WORD_W-1:0] i_rx_fifo_pulled_data,
    input  wire logic [NUM_CH-1:0]        i_rx_fifo_empty,
    output logic [NUM_CH-1:0]             o_tx_fifo_push,
    output logic [WORD_W-1:0]             o_tx_fifo_pushed_data,
    input  wire logic [NUM_CH-1:0]        i_tx_fifo_full,
    output logic [CH_W-1:0]               o_channel,
    output logic                          o_dir,
    output logic                          o_cond_tx
);
    localparam int c_BEATS  = WORD_W / SMI_W;
    localparam int c_BEAT_W = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_P      = c_BEATS * (SMI_W - 1) - 1;

    // Strobe synchronisers idle high so reset never fakes a falling edge.
    logic [2:0] r_soe_sync, r_swe_sync;
    logic       w_rx_beat, w_tx_beat;

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_soe_sync <= 3'b111;
            r_swe_sync <= 3'b111;
        end else begin
            r_soe_sync <= {r_soe_sync[1:0], bus.i_smi_soe_se};
            r_swe_sync <= {r_swe_sync[1:0], bus.i_smi_swe_srw};
        end
    end

    assign w_rx_beat = r_soe_sync[2] & ~r_soe_sync[1] & ~o_dir;
    assign w_tx_beat = r_swe_sync[2] & ~r_swe_sync[1] & o_dir;

    logic              w_fetch, w_load, w_wr_ch, w_wr_dir;
    logic [CH_W-1:0]   w_pend_ch, r_pend_ch;
    logic              w_pend_dir, r_pend_dir, r_pend, w_pend_any, w_apply;
    logic [c_BEAT_W-1:0] r_rx_beat, r_tx_state, w_tx_state_nxt;

    assign w_fetch    = bus.i_cs & bus.i_fetch_cmd;
    assign w_load     = bus.i_cs & bus.i_load_cmd & ~bus.i_fetch_cmd;
    assign w_wr_ch    = w_load && (bus.i_ioc == 5'd2)
                        && (32'(bus.i_data_in[CH_W-1:0]) < NUM_CH);
    assign w_wr_dir   = w_load && (bus.i_ioc == 5'd3);
    assign w_pend_ch  = w_wr_ch  ? bus.i_data_in[CH_W-1:0] : r_pend_ch;
    assign w_pend_dir = w_wr_dir ? bus.i_data_in[0]        : r_pend_dir;
    assign w_pend_any = r_pend | w_wr_ch | w_wr_dir;
    assign w_apply    = w_pend_any && (r_rx_beat == '0) && (r_tx_state == '0);

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_pend_ch  <= '0;
            r_pend_dir <= 1'b0;
            r_pend     <= 1'b0;
            o_channel  <= '0;
            o_dir      <= 1'b0;
        end else begin
            r_pend_ch  <= w_pend_ch;
            r_pend_dir <= w_pend_dir;
            if (w_apply) begin
                o_channel <= w_pend_ch;
                o_dir     <= w_pend_dir;
                r_pend    <= 1'b0;
            end else begin
                r_pend    <= w_pend_any;
            end
        end
    end

    // ---------------- RX path ----------------
    logic [WORD_W-1:0] r_rx_word, w_rx_sel;
    logic              r_rx_valid, w_pull_en;

    assign w_rx_sel  = i_rx_fifo_pulled_data[o_channel*WORD_W +: WORD_W];
    // A pull is withheld while a channel switch lands so the word goes to the new channel.
    assign w_pull_en = ~i_rst & ~o_dir & ~r_rx_valid & ~i_rx_fifo_empty[o_channel] & ~w_apply;

    always_comb begin
        o_rx_fifo_pull = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_rx_fifo_pull[c] = w_pull_en && (o_channel == CH_W'(c));
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_rx_word          <= '0;
            r_rx_valid         <= 1'b0;
            r_rx_beat          <= '0;
            bus.o_smi_data_out <= '0;
        end else begin
            if (w_rx_beat) begin
                if (!r_rx_valid) begin
                    bus.o_smi_data_out <= '0;
                end else begin
                    bus.o_smi_data_out <= r_rx_word[r_rx_beat*SMI_W +: SMI_W];
                    if (r_rx_beat == c_BEAT_W'(c_BEATS - 1)) begin
                        r_rx_beat  <= '0;
                        r_rx_valid <= 1'b0;
                    end else begin
                        r_rx_beat  <= r_rx_beat + 1'b1;
                    end
                end
            end
            if (w_pull_en) begin
                r_rx_word  <= w_rx_sel;
                r_rx_valid <= 1'b1;
            end
            if (w_apply) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign bus.o_smi_read_req  = ~o_dir & (r_rx_valid | ~i_rx_fifo_empty[o_channel]);
    assign bus.o_smi_write_req = o_dir & ~i_tx_fifo_full[o_channel];

    // ---------------- TX path ----------------
    logic [SMI_W-1:0] w_d;
    logic [c_P-1:0]   r_tx_acc, w_tx_acc_nxt;
    logic             r_tx_cond, w_tx_cond_nxt, w_tx_last, w_sync_inc;

    assign w_d = bus.i_smi_data_in;

    always_comb begin
        w_tx_acc_nxt   = r_tx_acc;
        w_tx_cond_nxt  = r_tx_cond;
        w_tx_state_nxt = r_tx_state;
        w_tx_last      = 1'b0;
        w_sync_inc     = 1'b0;
        if (w_tx_beat) begin
            if (w_d[SMI_W-1]) begin
                w_sync_inc    = (r_tx_state != '0);
                w_tx_acc_nxt  = c_P'(w_d[SMI_W-3:0]);
                w_tx_cond_nxt = w_d[SMI_W-2];
                if (c_BEATS == 1) begin
                    w_tx_last      = 1'b1;
                    w_tx_state_nxt = '0;
                end else begin
                    w_tx_state_nxt = c_BEAT_W'(1);
                end
            end else if (r_tx_state == '0) begin
                w_sync_inc = 1'b1;
            end else begin
                w_tx_acc_nxt = (r_tx_acc << (SMI_W - 1)) | c_P'(w_d[SMI_W-2:0]);
                if (r_tx_state == c_BEAT_W'(c_BEATS - 1)) begin
                    w_tx_last      = 1'b1;
                    w_tx_state_nxt = '0;
                end else begin
                    w_tx_state_nxt = r_tx_state + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_tx_state            <= '0;
            r_tx_acc              <= '0;
            r_tx_cond             <= 1'b0;
            o_tx_fifo_push        <= '0;
            o_tx_fifo_pushed_data <= '0;
            o_cond_tx             <= 1'b0;
        end else begin
            r_tx_state     <= w_tx_state_nxt;
            r_tx_acc       <= w_tx_acc_nxt;
            r_tx_cond      <= w_tx_cond_nxt;
            o_tx_fifo_push <= '0;
            if (w_tx_last && !i_tx_fifo_full[o_channel]) begin
                for (int c = 0; c < NUM_CH; c++) begin
                    o_tx_fifo_push[c] <= (o_channel == CH_W'(c));
                end
                o_tx_fifo_pushed_data <= WORD_W'(w_tx_acc_nxt);
                o_cond_tx             <= w_tx_cond_nxt;
            end
        end
    end

    // ---------------- Error counters and register file ----------------
    logic [CNT_W-1:0] r_cnt_under, r_cnt_over, r_cnt_sync;
    logic             w_under_inc, w_over_inc;
    logic [7:0]       w_rd_mux;

    assign w_under_inc = w_rx_beat & ~r_rx_valid;
    assign w_over_inc  = w_tx_last & i_tx_fifo_full[o_channel];

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_cnt_under <= '0;
            r_cnt_over  <= '0;
            r_cnt_sync  <= '0;
        end else begin
            if (w_under_inc && r_cnt_under != '1) r_cnt_under <= r_cnt_under + 1'b1;
            if (w_over_inc  && r_cnt_over  != '1) r_cnt_over  <= r_cnt_over + 1'b1;
            if (w_sync_inc  && r_cnt_sync  != '1) r_cnt_sync  <= r_cnt_sync + 1'b1;
            if (w_load && bus.i_ioc == 5'd4) r_cnt_under <= '0;
            if (w_load && bus.i_ioc == 5'd5) r_cnt_over  <= '0;
            if (w_load && bus.i_ioc == 5'd6) r_cnt_sync  <= '0;
        end
    end

    always_comb begin
        w_rd_mux = 8'h00;
        case (bus.i_ioc)
            5'd0: w_rd_mux = VERSION;
            5'd1: w_rd_mux = {3'b000, r_rx_valid, r_pend, o_dir,
                              i_tx_fifo_full[o_channel], i_rx_fifo_empty[o_channel]};
            5'd4: w_rd_mux = r_cnt_under[7:0];
            5'd5: w_rd_mux = r_cnt_over[7:0];
            5'd6: w_rd_mux = r_cnt_sync[7:0];
            default: w_rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            bus.o_data_out <= 8'h00;
        end else if (w_fetch) begin
            bus.o_data_out <= w_rd_mux;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_smi_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_smi_stream_ctrl
// Brief    : Scoreboard bench for smi_stream_ctrl with directed SMI/IOC vectors.
// Revision : 1.0
// ============================================================================
module tb_smi_stream_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    smi_stream_ctrl_if #(.SMI_W(8)) bus ();

    logic [1:0]  rx_pull, rx_empty, tx_push, tx_full;
    logic [63:0] rx_data;
    logic [31:0] tx_data;
    logic [0:0]  channel;
    logic        dir, cond_tx;

    smi_stream_ctrl dut (
        .i_sys_clk             (clk),
        .i_rst                 (rst),
        .bus                   (bus),
        .o_rx_fifo_pull        (rx_pull),
        .i_rx_fifo_pulled_data (rx_data),
        .i_rx_fifo_empty       (rx_empty),
        .o_tx_fifo_push        (tx_push),
        .o_tx_fifo_pushed_data (tx_data),
        .i_tx_fifo_full        (tx_full),
        .o_channel             (channel),
        .o_dir                 (dir),
        .o_cond_tx             (cond_tx)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Show-ahead RX FIFO model, one per channel.
    logic [31:0] rx_mem [2][8];
    int          wr_ptr [2] = '{0, 0};
    int          rd_ptr [2] = '{0, 0};
    int          pull_cnt [2] = '{0, 0};
    logic [1:0]  pull_q = 2'b00;

    for (genvar c = 0; c < 2; c++) begin : g_fifo
        assign rx_empty[c]         = (rd_ptr[c] == wr_ptr[c]);
        assign rx_data[c*32 +: 32] = rx_mem[c][rd_ptr[c] % 8];
    end

    always @(negedge clk) begin
        pull_q = rx_pull;
        for (int c = 0; c < 2; c++) if (rx_pull[c]) pull_cnt[c]++;
    end
    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) if (pull_q[c]) rd_ptr[c] <= rd_ptr[c] + 1;
    end

    task automatic fifo_load(input int ch, input logic [31:0] w);
        rx_mem[ch][wr_ptr[ch] % 8] = w;
        wr_ptr[ch]++;
    endtask

    // Scoreboard queues
    typedef struct {
        logic [1:0]  onehot;
        logic [31:0] data;
        logic        cond;
    } push_t;
    logic [7:0] exp_rx  [$];
    logic [7:0] exp_reg [$];
    push_t      exp_push[$];

    always @(posedge bus.i_smi_soe_se) begin
        if (!rst) begin
            if (exp_rx.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL rx_unexpected: got %h, expected none", bus.o_smi_data_out);
            end else begin
                check("rx_beat", 32'(bus.o_smi_data_out), 32'(exp_rx.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        push_t e;
        if (!rst && tx_push != 2'b00) begin
            if (exp_push.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL push_unexpected: got ch %b data %h, expected none", tx_push, tx_data);
            end else begin
                e = exp_push.pop_front();
                check("push_ch",   32'(tx_push), 32'(e.onehot));
                check("push_data", tx_data, e.data);
                check("push_cond", 32'(cond_tx), 32'(e.cond));
            end
        end
    end

    logic fetch_d = 1'b0;
    always @(posedge clk) fetch_d <= bus.i_cs & bus.i_fetch_cmd;
    always @(negedge clk) begin
        if (fetch_d) begin
            if (exp_reg.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL reg_unexpected: got %h, expected none", bus.o_data_out);
            end else begin
                check("reg_read", 32'(bus.o_data_out), 32'(exp_reg.pop_front()));
            end
        end
    end

    // Stimulus tasks
    task automatic smi_read(input logic [7:0] exp);
        exp_rx.push_back(exp);
        @(negedge clk) bus.i_smi_soe_se = 1'b0;
        repeat (6) @(negedge clk);
        bus.i_smi_soe_se = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic smi_write(input logic [7:0] d);
        @(negedge clk);
        bus.i_smi_data_in = d;
        bus.i_smi_swe_srw = 1'b0;
        repeat (6) @(negedge clk);
        bus.i_smi_swe_srw = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic reg_read(input logic [4:0] a, input logic [7:0] exp);
        exp_reg.push_back(exp);
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_fetch_cmd = 1'b1; bus.i_ioc = a;
        @(negedge clk);
        bus.i_cs = 1'b0; bus.i_fetch_cmd = 1'b0;
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.i_cs = 1'b1; bus.i_load_cmd = 1'b1; bus.i_ioc = a; bus.i_data_in = d;
        @(negedge clk);
        bus.i_cs = 1'b0; bus.i_load_cmd = 1'b0;
    endtask

    task automatic expect_push(input int ch, input logic [31:0] d, input logic c);
        push_t e;
        e.onehot = 2'b01 << ch;
        e.data   = d;
        e.cond   = c;
        exp_push.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.i_ioc = '0; bus.i_data_in = '0; bus.i_cs = 1'b0;
        bus.i_fetch_cmd = 1'b0; bus.i_load_cmd = 1'b0;
        bus.i_smi_soe_se = 1'b1; bus.i_smi_swe_srw = 1'b1; bus.i_smi_data_in = '0;
        tx_full = 2'b00;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_channel", 32'(channel), 0);
        check("rst_dir",     32'(dir), 0);
        check("rst_push",    32'(tx_push), 0);
        check("rst_cond",    32'(cond_tx), 0);
        check("rst_smi_out", 32'(bus.o_smi_data_out), 0);
        check("rst_readreq", 32'(bus.o_smi_read_req), 0);
        reg_read(5'd0, 8'h02);
        reg_read(5'd1, 8'h01);

        // RX ordering
        fifo_load(0, 32'hA1B2C3D4);
        repeat (3) @(negedge clk);
        check("rx_readreq", 32'(bus.o_smi_read_req), 1);
        reg_read(5'd1, 8'h11);
        smi_read(8'hD4); smi_read(8'hC3); smi_read(8'hB2); smi_read(8'hA1);
        check("rx_pulls_ch0", pull_cnt[0], 1);

        // RX underrun
        smi_read(8'h00); smi_read(8'h00);
        reg_read(5'd4, 8'h02);
        reg_write(5'd4, 8'h00);
        reg_read(5'd4, 8'h00);

        // TX framing
        reg_write(5'd3, 8'h01);
        @(negedge clk);
        check("tx_dir", 32'(dir), 1);
        check("tx_writereq", 32'(bus.o_smi_write_req), 1);
        expect_push(0, {5'b0, 6'h25, 7'h12, 7'h34, 7'h56}, 1'b1);
        smi_write(8'hE5); smi_write(8'h12); smi_write(8'h34); smi_write(8'h56);

        // TX resync
        expect_push(0, {5'b0, 6'h01, 21'h0}, 1'b0);
        smi_write(8'h12); smi_write(8'h80); smi_write(8'h01); smi_write(8'h81);
        smi_write(8'h00); smi_write(8'h00); smi_write(8'h00);
        reg_read(5'd6, 8'h02);
        check("tx_cond_after_resync", 32'(cond_tx), 0);

        // TX overflow
        tx_full = 2'b01;
        @(negedge clk);
        check("ovf_writereq", 32'(bus.o_smi_write_req), 0);
        smi_write(8'h80); smi_write(8'h00); smi_write(8'h00); smi_write(8'h00);
        reg_read(5'd5, 8'h01);
        tx_full = 2'b00;

        // Channel switch mid-word
        reg_write(5'd3, 8'h00);
        fifo_load(0, 32'h11223344);
        fifo_load(1, 32'h55667788);
        repeat (3) @(negedge clk);
        check("sw_dir", 32'(dir), 0);
        smi_read(8'h44); smi_read(8'h33);
        reg_write(5'd2, 8'h01);
        repeat (2) @(negedge clk);
        check("sw_ch_hold", 32'(channel), 0);
        reg_read(5'd1, 8'h19);
        smi_read(8'h22); smi_read(8'h11);
        repeat (4) @(negedge clk);
        check("sw_ch_new", 32'(channel), 1);
        check("sw_pulls_ch0", pull_cnt[0], 2);
        check("sw_pulls_ch1", pull_cnt[1], 1);
        smi_read(8'h88); smi_read(8'h77); smi_read(8'h66); smi_read(8'h55);
        reg_read(5'd1, 8'h01);

        repeat (10) @(negedge clk);
        check("left_rx",   exp_rx.size(), 0);
        check("left_push", exp_push.size(), 0);
        check("left_reg",  exp_reg.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
